// File: rtl/apb_mem_ctrl.sv
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

// ============================================================================
// Module   : apb_mem_ctrl
// Purpose  : APB slave bridging single-word transfers onto a synchronous
//            memory port, with optional wait states, out-of-range error
//            response and a deferred memory-dump strobe issued only when idle.
// Revision : 1.0 - initial release
// ============================================================================
module apb_mem_ctrl #(
    parameter int DATA_WIDTH  = `DATA_WIDTH,
    parameter int ADDR_WIDTH  = `ADDR_WIDTH,
    parameter int MEM_DEPTH   = 2**ADDR_WIDTH,
    parameter int WAIT_STATES = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic                  i_pwrite,
    input  logic [ADDR_WIDTH-1:0] i_paddr,
    input  logic [DATA_WIDTH-1:0] i_pwdata,
    output logic [DATA_WIDTH-1:0] o_prdata,
    output logic                  o_pready,
    output logic                  o_pslverr,
    output logic                  o_mem_en,
    output logic                  o_mem_wr,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data_w,
    input  logic [DATA_WIDTH-1:0] i_mem_data_r,
    input  logic                  i_dump_req,
    output logic                  o_mem_dump
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MEM  = 3'd1,
        S_CAPT = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] c_depth     = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [3:0]          c_wait_load = 4'(WAIT_STATES);

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [3:0]              r_wait_cnt;
    logic                    r_dump_pend;
    logic                    w_setup;
    logic                    w_oob;
    logic                    w_dump_fire;

    assign w_setup      = i_psel && !i_penable;
    assign w_oob        = ({1'b0, i_paddr} >= c_depth);
    // Dump strobes only while no transfer is in flight.
    assign w_dump_fire  = (r_state == S_IDLE) && r_dump_pend;
    assign o_mem_dump   = w_dump_fire;
    assign o_mem_addr   = r_addr;
    assign o_mem_data_w = r_wdata;

    // State register plus latching of the setup phase and captured read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_setup) begin
                r_addr  <= i_paddr;
                r_wdata <= i_pwdata;
                r_write <= i_pwrite;
            end
            if (r_state == S_CAPT && !r_write) begin
                r_rdata <= i_mem_data_r;
            end
        end
    end

    // Wait-state counter: loaded on the way into WAIT, counts down inside it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt <= 4'd0;
        end else if (r_state == S_CAPT) begin
            r_wait_cnt <= c_wait_load;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end

    // Pending dump flag; a request arriving while the strobe fires re-arms it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dump_pend <= 1'b0;
        end else if (w_dump_fire) begin
            r_dump_pend <= i_dump_req;
        end else if (i_dump_req) begin
            r_dump_pend <= 1'b1;
        end
    end

    // Next-state and Moore outputs; deselect during the access aborts quietly.
    always_comb begin
        w_next    = r_state;
        o_mem_en  = 1'b0;
        o_mem_wr  = 1'b0;
        o_pready  = 1'b0;
        o_pslverr = 1'b0;
        o_prdata  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    w_next = w_oob ? S_ERR : S_MEM;
                end
            end
            S_MEM: begin
                o_mem_en = 1'b1;
                o_mem_wr = r_write;
                w_next   = i_psel ? S_CAPT : S_IDLE;
            end
            S_CAPT: begin
                if (!i_psel) begin
                    w_next = S_IDLE;
                end else if (WAIT_STATES > 0) begin
                    w_next = S_WAIT;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_WAIT: begin
                if (!i_psel) begin
                    w_next = S_IDLE;
                end else if (r_wait_cnt <= 4'd1) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                o_pready = 1'b1;
                o_prdata = r_write ? '0 : r_rdata;
                w_next   = S_IDLE;
            end
            S_ERR: begin
                o_pready  = 1'b1;
                o_pslverr = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
